// File: rtl/fec_pkg.sv
// Shared constants and helpers for the K=7, rate-1/2 convolutional code.
// The FEC transmit encoder and the receive-side Viterbi decoder both use this package.
package fec_pkg;

    localparam int unsigned CC_K      = 7;
    localparam int unsigned CC_M      = CC_K - 1;
    localparam int unsigned CC_STATES = 1 << CC_M;

    localparam logic [CC_K-1:0] CC_G1 = 7'o171;
    localparam logic [CC_K-1:0] CC_G2 = 7'o133;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } cc_dec_state_e;

    // Returns {Y, X}. The tap vector is {u, s0..s5}, so each generator's MSB weights the newest bit.
    function automatic logic [1:0] cc_branch_out(input logic [CC_M-1:0] state, input logic u);
        logic [CC_K-1:0] taps;
        taps = {u, state[0], state[1], state[2], state[3], state[4], state[5]};
        return {^(taps & CC_G2), ^(taps & CC_G1)};
    endfunction

    // Hamming distance between two hard-decision pairs (0..2).
    function automatic logic [1:0] cc_hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/cc_dec_if.sv
// Coded-pair input and decoded-bit output bundle of the Viterbi decoder.
interface cc_dec_if;

    logic       valid_in;
    logic [1:0] z_in;
    logic       last_in;
    logic       in_ready;
    logic       valid_out;
    logic       out_bit;
    logic       frame_done;

    modport master (
        output valid_in, z_in, last_in,
        input  in_ready, valid_out, out_bit, frame_done
    );

    modport slave (
        input  valid_in, z_in, last_in,
        output in_ready, valid_out, out_bit, frame_done
    );

endinterface

// File: rtl/cc_acs.sv
// Add-compare-select for one trellis state, with register-exchange survivor update.
module cc_acs #(
    parameter int unsigned PM_W     = 6,
    parameter int unsigned TB_DEPTH = 32,
    parameter logic        DEC_BIT  = 1'b0
) (
    input  logic [PM_W-1:0]     pm0,
    input  logic [PM_W-1:0]     pm1,
    input  logic [1:0]          bm0,
    input  logic [1:0]          bm1,
    input  logic [TB_DEPTH-1:0] surv0,
    input  logic [TB_DEPTH-1:0] surv1,
    output logic [PM_W-1:0]     pm_new,
    output logic [TB_DEPTH-1:0] surv_new
);

    logic [PM_W-1:0]     cand0;
    logic [PM_W-1:0]     cand1;
    logic [PM_W-1:0]     diff;
    logic                take1;
    logic [TB_DEPTH-1:0] sel;

    // Modular compare: cand1 wins only when strictly smaller, so ties keep p0.
    always_comb begin
        cand0    = pm0 + PM_W'(bm0);
        cand1    = pm1 + PM_W'(bm1);
        diff     = cand1 - cand0;
        take1    = diff[PM_W-1];
        pm_new   = take1 ? cand1 : cand0;
        sel      = take1 ? surv1 : surv0;
        surv_new = (sel << 1) | TB_DEPTH'(DEC_BIT);
    end

endmodule

// File: rtl/cc_dec.sv
// Hard-decision register-exchange Viterbi decoder for the K=7 (171,133) code.
// Emits one bit per accepted pair; zero-tail frames are flushed from state 0's survivor.
module cc_dec
    import fec_pkg::*;
#(
    parameter int unsigned TB_DEPTH = 32,
    parameter int unsigned PM_W     = 6
) (
    input  logic    clk,
    input  logic    reset,
    cc_dec_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(TB_DEPTH);
    localparam int unsigned HALF  = CC_STATES / 2;
    localparam int unsigned NODES = 2 * CC_STATES - 1;

    localparam logic [PM_W-1:0]  PM_INIT = PM_W'(12);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] EMIT_K  = CNT_W'(TB_DEPTH - 1);

    cc_dec_state_e state_q, state_d;

    logic [PM_W-1:0]     pm_q     [CC_STATES];
    logic [PM_W-1:0]     pm_cur   [CC_STATES];
    logic [PM_W-1:0]     pm_new   [CC_STATES];
    logic [TB_DEPTH-1:0] surv_q   [CC_STATES];
    logic [TB_DEPTH-1:0] surv_cur [CC_STATES];
    logic [TB_DEPTH-1:0] surv_new [CC_STATES];

    logic [PM_W-1:0] node_pm  [NODES];
    logic [CC_M-1:0] node_idx [NODES];
    logic [CC_M-1:0] best;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    k_cur, n_cur;
    logic [TB_DEPTH-1:0] sr_q;

    logic in_ready_q;
    logic valid_q, valid_d;
    logic bit_q, bit_d;
    logic done_q, done_d;
    logic accept, upd, load_sr;

    function automatic logic pm_less(input logic [PM_W-1:0] a, input logic [PM_W-1:0] b);
        logic [PM_W-1:0] d;
        d = a - b;
        return d[PM_W-1];
    endfunction

    assign accept = bus.valid_in & in_ready_q;

    // A frame's first pair starts from state 0 with zero survivors.
    always_comb begin
        for (int s = 0; s < int'(CC_STATES); s++) begin
            if (state_q == ST_IDLE) begin
                pm_cur[s]   = (s == 0) ? '0 : PM_INIT;
                surv_cur[s] = '0;
            end else begin
                pm_cur[s]   = pm_q[s];
                surv_cur[s] = surv_q[s];
            end
        end
    end

    for (genvar ns = 0; ns < int'(CC_STATES); ns++) begin : g_acs
        localparam int unsigned P0 = ns / 2;
        localparam int unsigned P1 = ns / 2 + HALF;
        localparam logic        U  = 1'(ns % 2);

        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = cc_hamming2(bus.z_in, cc_branch_out(CC_M'(P0), U));
        assign bm1 = cc_hamming2(bus.z_in, cc_branch_out(CC_M'(P1), U));

        cc_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH),
            .DEC_BIT  (U)
        ) u_acs (
            .pm0      (pm_cur[P0]),
            .pm1      (pm_cur[P1]),
            .bm0      (bm0),
            .bm1      (bm1),
            .surv0    (surv_cur[P0]),
            .surv1    (surv_cur[P1]),
            .pm_new   (pm_new[ns]),
            .surv_new (surv_new[ns])
        );
    end

    // Heap-ordered min tree; the left child holds lower state indices and wins ties.
    always_comb begin
        for (int i = 0; i < int'(CC_STATES); i++) begin
            node_pm[int'(CC_STATES) - 1 + i]  = pm_new[i];
            node_idx[int'(CC_STATES) - 1 + i] = CC_M'(i);
        end
        for (int n = int'(CC_STATES) - 2; n >= 0; n--) begin
            if (pm_less(node_pm[2*n+2], node_pm[2*n+1])) begin
                node_pm[n]  = node_pm[2*n+2];
                node_idx[n] = node_idx[2*n+2];
            end else begin
                node_pm[n]  = node_pm[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end
        end
        best = node_idx[0];
    end

    assign k_cur = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign n_cur = (k_cur == CNT_MAX) ? CNT_MAX : k_cur + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        valid_d = 1'b0;
        bit_d   = 1'b0;
        done_d  = 1'b0;
        upd     = 1'b0;
        load_sr = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    upd   = 1'b1;
                    cnt_d = n_cur;
                    if (bus.last_in) begin
                        state_d = ST_DRAIN;
                        load_sr = 1'b1;
                        valid_d = 1'b1;
                        bit_d   = surv_new[0][IDX_W'(n_cur - CNT_W'(1))];
                        rem_d   = n_cur - CNT_W'(1);
                        done_d  = (n_cur == CNT_W'(1));
                    end else begin
                        state_d = ST_RUN;
                        if (k_cur >= EMIT_K) begin
                            valid_d = 1'b1;
                            bit_d   = surv_new[best][TB_DEPTH-1];
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (rem_q != '0) begin
                    valid_d = 1'b1;
                    bit_d   = sr_q[IDX_W'(rem_q - CNT_W'(1))];
                    rem_d   = rem_q - CNT_W'(1);
                    done_d  = (rem_q == CNT_W'(1));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            sr_q       <= '0;
            in_ready_q <= 1'b1;
            valid_q    <= 1'b0;
            bit_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            in_ready_q <= (state_d != ST_DRAIN);
            valid_q    <= valid_d;
            bit_q      <= bit_d;
            done_q     <= done_d;
            if (load_sr) begin
                sr_q <= surv_new[0];
            end
        end
    end

    // Path metrics and survivors advance only on accepted pairs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < int'(CC_STATES); s++) begin
                pm_q[s]   <= '0;
                surv_q[s] <= '0;
            end
        end else if (upd) begin
            for (int s = 0; s < int'(CC_STATES); s++) begin
                pm_q[s]   <= pm_new[s];
                surv_q[s] <= surv_new[s];
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.valid_out  = valid_q;
    assign bus.out_bit    = bit_q;
    assign bus.frame_done = done_q;

endmodule
